// File: rtl/pixel_xform_pkg.sv
// rtl/pixel_xform_pkg.sv - shared state, CSR offset and transform mode constants
package pixel_xform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  localparam logic [2:0] CSR_CTRL = 3'd0;
  localparam logic [2:0] CSR_SRC  = 3'd1;
  localparam logic [2:0] CSR_DST  = 3'd2;
  localparam logic [2:0] CSR_CNT  = 3'd3;
  localparam logic [2:0] CSR_MODE = 3'd4;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_GRAY = 2'd2;
  localparam logic [1:0] MODE_THR  = 2'd3;

endpackage

// File: rtl/pixel_xform_alu.sv
// rtl/pixel_xform_alu.sv - combinational per-pixel transform (pass, invert, gray, threshold)
module pixel_xform_alu
  import pixel_xform_pkg::*;
(
  input  logic [23:0] i_pixel,
  input  logic [1:0]  i_mode,
  input  logic [7:0]  i_param,
  output logic [31:0] o_pixel
);

  logic [9:0] w_sum;
  logic [7:0] w_gray;

  // Weighted sum R + 2G + B fits in 10 bits; >>2 keeps the result within 0..255
  assign w_sum  = {2'b00, i_pixel[23:16]} + {1'b0, i_pixel[15:8], 1'b0} + {2'b00, i_pixel[7:0]};
  assign w_gray = w_sum[9:2];

  always_comb begin
    o_pixel = 32'h0;
    case (i_mode)
      MODE_PASS: o_pixel = {8'h00, i_pixel};
      MODE_INV:  o_pixel = {8'h00, ~i_pixel};
      MODE_GRAY: o_pixel = {8'h00, w_gray, w_gray, w_gray};
      MODE_THR:  o_pixel = (w_gray >= i_param) ? 32'h00FF_FFFF : 32'h0;
      default:   o_pixel = 32'h0;
    endcase
  end

endmodule

// File: rtl/pixel_xform_accel.sv
// rtl/pixel_xform_accel.sv - CSR slave plus read/transform/write master engine for pixel buffers
module pixel_xform_accel
  import pixel_xform_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int BYTES_PER_PIX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [31:0]       master_writedata
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RD_REQ  = ST_RD_REQ;
  localparam logic [1:0] S_RD_WAIT = ST_RD_WAIT;
  localparam logic [1:0] S_WR_REQ  = ST_WR_REQ;

  logic [1:0]        r_state;
  logic [31:0]       r_src;
  logic [31:0]       r_dst;
  logic [31:0]       r_cnt;
  logic [1:0]        r_mode;
  logic [7:0]        r_param;
  logic [31:0]       r_idx;
  logic [31:0]       r_wdata;

  logic              w_idle;
  logic              w_start;
  logic              w_cfg_wr;
  logic [ADDR_W-1:0] w_off;
  logic [31:0]       w_alu_pixel;
  logic              w_unused;

  assign w_idle   = (r_state == S_IDLE);
  assign w_start  = slave_write && (slave_address == CSR_CTRL) && w_idle;
  // The CSRs double as the job's latched configuration, so they freeze while busy
  assign w_cfg_wr = slave_write && w_idle;
  assign w_off    = ADDR_W'(r_idx) * ADDR_W'(BYTES_PER_PIX);

  pixel_xform_alu u_alu (
    .i_pixel (master_readdata[23:0]),
    .i_mode  (r_mode),
    .i_param (r_param),
    .o_pixel (w_alu_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= 32'h0;
      r_dst   <= 32'h0;
      r_cnt   <= 32'h0;
      r_mode  <= 2'h0;
      r_param <= 8'h0;
      r_idx   <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      if (w_cfg_wr) begin
        case (slave_address)
          CSR_SRC:  r_src <= slave_writedata;
          CSR_DST:  r_dst <= slave_writedata;
          CSR_CNT:  r_cnt <= slave_writedata;
          CSR_MODE: begin
            r_mode  <= slave_writedata[1:0];
            r_param <= slave_writedata[15:8];
          end
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_idx <= 32'h0;
            if (r_cnt != 32'h0) r_state <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (!master_waitrequest) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (master_readdatavalid) begin
            r_wdata <= w_alu_pixel;
            r_state <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!master_waitrequest) begin
            r_idx   <= r_idx + 32'd1;
            r_state <= (r_idx + 32'd1 == r_cnt) ? S_IDLE : S_RD_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and address decode straight from state so an async reset drops them at once
  assign master_read      = (r_state == S_RD_REQ);
  assign master_write     = (r_state == S_WR_REQ);
  assign master_writedata = r_wdata;

  always_comb begin
    master_address = '0;
    case (r_state)
      S_RD_REQ: master_address = ADDR_W'(r_src) + w_off;
      S_WR_REQ: master_address = ADDR_W'(r_dst) + w_off;
      default:  master_address = '0;
    endcase
  end

  assign slave_waitrequest = slave_read && (slave_address == CSR_CTRL) && !w_idle;

  always_comb begin
    slave_readdata = 32'h0;
    case (slave_address)
      CSR_CTRL: slave_readdata = {31'h0, w_idle};
      CSR_SRC:  slave_readdata = r_src;
      CSR_DST:  slave_readdata = r_dst;
      CSR_CNT:  slave_readdata = r_cnt;
      CSR_MODE: slave_readdata = {16'h0, r_param, 6'h0, r_mode};
      default:  slave_readdata = 32'h0;
    endcase
  end

  assign w_unused = ^{master_readdata[31:24], slave_writedata[31:16], slave_writedata[7:2]};

endmodule

// File: tb/tb_pixel_xform_accel.sv
// tb/tb_pixel_xform_accel.sv - directed self-checking bench for pixel_xform_accel
module tb_pixel_xform_accel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [2:0]  slave_address = 3'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'h0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = 32'h0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  logic [31:0] smem [0:4095];
  logic [31:0] wmem [0:4095];

  int checks = 0;
  int errors = 0;
  int rd_acc = 0, wr_acc = 0, stall_err = 0, overlap_err = 0;
  bit rand_mode = 1'b0;

  bit          rd_pend = 1'b0;
  int          rd_lat = 0;
  logic [31:0] rd_data = 32'h0;
  bit          prev_srd = 1'b0, prev_swr = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;

  pixel_xform_accel #(.ADDR_W(32), .BYTES_PER_PIX(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  // Memory slave: decides every handshake at the negedge ahead of the posedge it applies to
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 1'b0;
      master_readdatavalid = 1'b0;
      master_waitrequest = 1'b0;
      prev_srd = 1'b0;
      prev_swr = 1'b0;
    end else begin
      if (prev_srd && (master_read !== 1'b1 || master_address !== prev_addr)) stall_err++;
      if (prev_swr && (master_write !== 1'b1 || master_address !== prev_addr ||
                       master_writedata !== prev_data)) stall_err++;
      if (master_read === 1'b1 && master_write === 1'b1) overlap_err++;
      master_readdatavalid = 1'b0;
      master_readdata = 32'hDEAD_BEEF;
      if (rd_pend) begin
        rd_lat--;
        if (rd_lat == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = rd_data;
          rd_pend = 1'b0;
        end
      end
      master_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      if (master_read === 1'b1 && !master_waitrequest) begin
        rd_pend = 1'b1;
        rd_lat = rand_mode ? int'($urandom_range(1, 5)) : 1;
        rd_data = smem[master_address[13:2]];
        rd_acc++;
      end
      if (master_write === 1'b1 && !master_waitrequest) begin
        wmem[master_address[13:2]] = master_writedata;
        wr_acc++;
      end
      prev_srd = (master_read === 1'b1) && master_waitrequest;
      prev_swr = (master_write === 1'b1) && master_waitrequest;
      prev_addr = master_address;
      prev_data = master_writedata;
    end
  end

  function automatic logic [31:0] model(input logic [31:0] px, input logic [1:0] m, input logic [7:0] p);
    int r, g, b, y;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    y = (r + 2 * g + b) / 4;
    case (m)
      2'd0:    return {8'h00, px[23:0]};
      2'd1:    return {8'h00, 8'(255 - r), 8'(255 - g), 8'(255 - b)};
      2'd2:    return {8'h00, 8'(y), 8'(y), 8'(y)};
      default: return (y >= int'(p)) ? 32'h00FF_FFFF : 32'h0;
    endcase
  endfunction

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    @(posedge clk);
    #1 slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read = 1'b1;
    #1 d = slave_readdata;
    @(posedge clk);
    #1 slave_read = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    slave_address = 3'd0;
    slave_read = 1'b1;
    #1;
    while (slave_waitrequest === 1'b1 && stalls < 3000) begin
      @(negedge clk);
      #1 stalls++;
    end
    d = slave_readdata;
    @(posedge clk);
    #1 slave_read = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt,
                         input logic [31:0] mode_word, output logic [31:0] st, output int stalls);
    csr_write(3'd1, src);
    csr_write(3'd2, dst);
    csr_write(3'd3, cnt);
    csr_write(3'd4, mode_word);
    csr_write(3'd0, 32'h1);
    read_status(st, stalls);
  endtask

  task automatic check_csrs_cleared(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), d);
      checks++;
      if (d !== ((a == 0) ? 32'h1 : 32'h0)) begin
        errors++;
        $display("FAIL %s_csr%0d got %h exp %h", tag, a, d, (a == 0) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (master_read !== 1'b0) begin errors++; $display("FAIL reset_master_read got %b exp 0", master_read); end
    checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL reset_master_write got %b exp 0", master_write); end
    checks++; if (master_address !== 32'h0) begin errors++; $display("FAIL reset_master_address got %h exp 0", master_address); end
    checks++; if (master_writedata !== 32'h0) begin errors++; $display("FAIL reset_master_writedata got %h exp 0", master_writedata); end
    checks++; if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_slave_waitrequest got %b exp 0", slave_waitrequest); end
    @(negedge clk) rst_n = 1'b1;
    check_csrs_cleared("reset");
  endtask

  task automatic test_reset_mid_job();
    bit found = 1'b0;
    int rd0, wr0;
    for (int i = 0; i < 4; i++) smem[12'h400 + i] = 32'h0011_2233 + i;
    csr_write(3'd1, 32'h1000);
    csr_write(3'd2, 32'h2000);
    csr_write(3'd3, 32'd4);
    csr_write(3'd4, 32'h0000_1203);
    csr_write(3'd0, 32'h1);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1 if (master_read === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_read_seen got 0 exp 1"); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (master_read !== 1'b0) begin errors++; $display("FAIL midreset_master_read got %b exp 0", master_read); end
    checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL midreset_master_write got %b exp 0", master_write); end
    rd0 = rd_acc;
    wr0 = wr_acc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (rd_acc != rd0 || wr_acc != wr0) begin
      errors++; $display("FAIL midreset_bus_quiet got rd+%0d wr+%0d exp 0", rd_acc - rd0, wr_acc - wr0);
    end
    check_csrs_cleared("midreset");
  endtask

  task automatic test_pass();
    logic [31:0] st;
    int stalls, rd0, wr0;
    for (int i = 0; i < 4; i++) smem[12'h400 + i] = 32'h0011_2233 + i;
    rd0 = rd_acc;
    wr0 = wr_acc;
    run_job(32'h1000, 32'h2000, 32'd4, 32'h0, st, stalls);
    checks++; if (st !== 32'h1) begin errors++; $display("FAIL pass_status got %h exp 1", st); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL pass_status_stall got %0d exp >0", stalls); end
    checks++; if (rd_acc - rd0 != 4) begin errors++; $display("FAIL pass_reads got %0d exp 4", rd_acc - rd0); end
    checks++; if (wr_acc - wr0 != 4) begin errors++; $display("FAIL pass_writes got %0d exp 4", wr_acc - wr0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wmem[12'h800 + i] !== 32'h0011_2233 + i) begin
        errors++; $display("FAIL pass_data%0d got %h exp %h", i, wmem[12'h800 + i], 32'h0011_2233 + i);
      end
    end
  endtask

  task automatic test_invert_gray();
    logic [31:0] st;
    int stalls;
    smem[12'h440] = 32'h00FF_8000;
    run_job(32'h1100, 32'h2100, 32'd1, 32'h1, st, stalls);
    checks++; if (wmem[12'h840] !== 32'h0000_7FFF) begin errors++; $display("FAIL invert_data got %h exp 00007fff", wmem[12'h840]); end
    run_job(32'h1100, 32'h2104, 32'd1, 32'h2, st, stalls);
    checks++; if (wmem[12'h841] !== 32'h007F_7F7F) begin errors++; $display("FAIL gray_data got %h exp 007f7f7f", wmem[12'h841]); end
    checks++; if (st !== 32'h1) begin errors++; $display("FAIL gray_status got %h exp 1", st); end
  endtask

  task automatic test_threshold();
    logic [31:0] st, d;
    int stalls;
    smem[12'h480] = 32'h0080_8080;
    smem[12'h481] = 32'h007F_7F7F;
    run_job(32'h1200, 32'h2200, 32'd2, 32'hFFFF_80FF, st, stalls);
    checks++; if (wmem[12'h880] !== 32'h00FF_FFFF) begin errors++; $display("FAIL thr_hi got %h exp 00ffffff", wmem[12'h880]); end
    checks++; if (wmem[12'h881] !== 32'h0) begin errors++; $display("FAIL thr_lo got %h exp 00000000", wmem[12'h881]); end
    csr_read(3'd4, d);
    checks++; if (d !== 32'h0000_8003) begin errors++; $display("FAIL thr_mode_csr got %h exp 00008003", d); end
  endtask

  task automatic test_random();
    logic [31:0] st, exp;
    int stalls, rd0, wr0, se0, ov0;
    for (int i = 0; i < 16; i++) smem[12'h500 + i] = $urandom;
    rd0 = rd_acc; wr0 = wr_acc; se0 = stall_err; ov0 = overlap_err;
    rand_mode = 1'b1;
    run_job(32'h1400, 32'h2400, 32'd16, 32'h0000_0002, st, stalls);
    rand_mode = 1'b0;
    checks++; if (st !== 32'h1) begin errors++; $display("FAIL rand_status got %h exp 1", st); end
    checks++; if (rd_acc - rd0 != 16) begin errors++; $display("FAIL rand_reads got %0d exp 16", rd_acc - rd0); end
    checks++; if (wr_acc - wr0 != 16) begin errors++; $display("FAIL rand_writes got %0d exp 16", wr_acc - wr0); end
    checks++; if (stall_err != se0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stall_err - se0); end
    checks++; if (overlap_err != ov0) begin errors++; $display("FAIL rand_overlap got %0d exp 0", overlap_err - ov0); end
    for (int i = 0; i < 16; i++) begin
      exp = model(smem[12'h500 + i], 2'd2, 8'h00);
      checks++;
      if (wmem[12'h900 + i] !== exp) begin
        errors++; $display("FAIL rand_data%0d got %h exp %h", i, wmem[12'h900 + i], exp);
      end
    end
  endtask

  task automatic test_count0();
    logic [31:0] st;
    int stalls, rd0, wr0;
    rd0 = rd_acc;
    wr0 = wr_acc;
    csr_write(3'd3, 32'd0);
    csr_write(3'd0, 32'h1);
    read_status(st, stalls);
    checks++; if (st !== 32'h1) begin errors++; $display("FAIL cnt0_status got %h exp 1", st); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL cnt0_stall got %0d exp 0", stalls); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (rd_acc != rd0 || wr_acc != wr0) begin
      errors++; $display("FAIL cnt0_bus_quiet got rd+%0d wr+%0d exp 0", rd_acc - rd0, wr_acc - wr0);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] st, d, exp;
    int stalls, rd0, wr0;
    for (int i = 0; i < 8; i++) smem[12'h600 + i] = 32'h9A40_10F0 + i * 32'h0001_0203;
    rd0 = rd_acc;
    wr0 = wr_acc;
    csr_write(3'd1, 32'h1800);
    csr_write(3'd2, 32'h2800);
    csr_write(3'd3, 32'd8);
    csr_write(3'd4, 32'h1);
    csr_write(3'd0, 32'h1);
    csr_write(3'd1, 32'h3000);
    csr_write(3'd2, 32'h3800);
    csr_write(3'd3, 32'd2);
    csr_write(3'd4, 32'h0000_5502);
    csr_write(3'd0, 32'h1);
    read_status(st, stalls);
    checks++; if (st !== 32'h1) begin errors++; $display("FAIL busy_status got %h exp 1", st); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL busy_status_stall got %0d exp >0", stalls); end
    repeat (10) @(negedge clk);
    checks++; if (rd_acc - rd0 != 8) begin errors++; $display("FAIL busy_reads got %0d exp 8", rd_acc - rd0); end
    checks++; if (wr_acc - wr0 != 8) begin errors++; $display("FAIL busy_writes got %0d exp 8", wr_acc - wr0); end
    for (int i = 0; i < 8; i++) begin
      exp = model(smem[12'h600 + i], 2'd1, 8'h00);
      checks++;
      if (wmem[12'hA00 + i] !== exp) begin
        errors++; $display("FAIL busy_data%0d got %h exp %h", i, wmem[12'hA00 + i], exp);
      end
    end
    csr_read(3'd1, d);
    checks++; if (d !== 32'h1800) begin errors++; $display("FAIL busy_src got %h exp 00001800", d); end
    csr_read(3'd2, d);
    checks++; if (d !== 32'h2800) begin errors++; $display("FAIL busy_dst got %h exp 00002800", d); end
    csr_read(3'd3, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL busy_cnt got %h exp 00000008", d); end
    csr_read(3'd4, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL busy_mode got %h exp 00000001", d); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_pass();
    test_invert_gray();
    test_threshold();
    test_random();
    test_count0();
    test_busy_writes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
